enc_cod_serializer: RTL and testbench

// - Read side of the encoder message/parity buffers: drains one RS codeword per frame onto a

---
 rtl/enc_pkg.sv | 36 +++
 rtl/enc_out_reg.sv | 35 +++
 rtl/enc_cod_serializer.sv | 137 +++++++++++++
 tb/tb_enc_cod_serializer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared parameters and types for the RS encoder output serializer.
// Beat geometry, FSM states and the parity-beat selection helper live here.
package enc_pkg;

  localparam int EGF_DIM     = 8;
  localparam int ENC_SYM     = 4;
  localparam int RSC_MES_LEN = 32;
  localparam int RSC_PAR_LEN = 16;

  localparam int MES_BEATS = RSC_MES_LEN / ENC_SYM;
  localparam int PAR_BEATS = RSC_PAR_LEN / ENC_SYM;
  localparam int MAX_BEATS = (MES_BEATS > PAR_BEATS) ? MES_BEATS : PAR_BEATS;
  localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int PAR_IDX_W = (PAR_BEATS > 1) ? $clog2(PAR_BEATS) : 1;

  typedef logic [EGF_DIM-1:0] sym_t;
  typedef sym_t [ENC_SYM-1:0] beat_t;
  typedef sym_t [RSC_PAR_LEN-1:0] par_t;
  typedef beat_t [PAR_BEATS-1:0] par_beats_t;

  typedef enum logic [1:0] {MES, WAIT_PAR, PAR} ser_state_t;

  typedef struct packed {
    beat_t data;
    logic  par;
    logic  last;
  } out_beat_t;

  // Parity beat k carries the highest-index symbols first.
  function automatic beat_t par_beat(input par_t slot, input logic [PAR_IDX_W-1:0] k);
    par_beats_t beats;
    beats = par_beats_t'(slot);
    return beats[PAR_IDX_W'(PAR_BEATS - 1) - k];
  endfunction

endpackage

// File: rtl/enc_out_reg.sv
// Single-entry valid/ready holding register for one output beat.
// Accepts a new beat whenever it is empty or its current beat is leaving.
module enc_out_reg
  import enc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  out_beat_t in_beat_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output out_beat_t out_beat_o
);

  logic      valid_q;
  out_beat_t beat_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_beat_o  = beat_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) beat_q <= in_beat_i;
    end
  end

endmodule

// File: rtl/enc_cod_serializer.sv
// Drains one RS codeword per frame: message beats pass through, then the
// captured parity is emitted highest symbols first, all via one output register.
module enc_cod_serializer
  import enc_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                mes_valid,
  output logic                                mes_ready,
  input  logic [ENC_SYM-1:0][EGF_DIM-1:0]     mes_data,
  input  logic                                par_valid,
  input  logic [RSC_PAR_LEN-1:0][EGF_DIM-1:0] par_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ENC_SYM-1:0][EGF_DIM-1:0]     out_data,
  output logic                                out_par,
  output logic                                out_last,
  output logic                                cw_done,
  output logic                                par_ovf
);

  if (RSC_MES_LEN % ENC_SYM != 0) begin : g_bad_mes_len
    $error("RSC_MES_LEN must be a multiple of ENC_SYM");
  end
  if (RSC_PAR_LEN % ENC_SYM != 0) begin : g_bad_par_len
    $error("RSC_PAR_LEN must be a multiple of ENC_SYM");
  end

  ser_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             slot_full_q;
  par_t             slot_q;
  logic             ovf_q;

  logic      load_ok;
  logic      mes_fire;
  logic      par_avail;
  logic      par_load;
  logic      last_mes;
  logic      last_par;
  logic      final_par;
  par_t      par_src;
  out_beat_t load_beat;
  out_beat_t out_beat;

  // An empty slot is bypassed so a parity pulse can feed beat 0 in the same cycle.
  assign par_src   = slot_full_q ? slot_q : par_t'(par_data);
  assign par_avail = slot_full_q || par_valid;
  assign last_mes  = (cnt_q == CNT_W'(MES_BEATS - 1));
  assign last_par  = (cnt_q == CNT_W'(PAR_BEATS - 1));

  assign mes_ready = (state_q == MES) && load_ok && !rst;
  assign mes_fire  = mes_valid && mes_ready;
  assign par_load  = (state_q != MES) && par_avail && load_ok;
  assign final_par = par_load && last_par;

  always_comb begin
    load_beat.data = beat_t'(mes_data);
    load_beat.par  = 1'b0;
    load_beat.last = 1'b0;
    if (par_load) begin
      load_beat.data = par_beat(par_src, cnt_q[PAR_IDX_W-1:0]);
      load_beat.par  = 1'b1;
      load_beat.last = last_par;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MES;
      cnt_q       <= '0;
      slot_full_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        MES: begin
          if (mes_fire) begin
            if (last_mes) begin
              cnt_q   <= '0;
              state_q <= par_avail ? PAR : WAIT_PAR;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        WAIT_PAR, PAR: begin
          if (par_load) begin
            if (last_par) begin
              cnt_q   <= '0;
              state_q <= MES;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= PAR;
            end
          end else if (par_avail) begin
            state_q <= PAR;
          end
        end
        default: begin
          state_q <= MES;
          cnt_q   <= '0;
        end
      endcase

      // The slot may refill in the very cycle its final beat is loaded out.
      if (par_valid && (!slot_full_q || final_par)) begin
        slot_full_q <= 1'b1;
      end else begin
        if (final_par) slot_full_q <= 1'b0;
        if (par_valid) ovf_q <= 1'b1;
      end
    end
  end

  // NOTE: parity storage has no reset; slot_full_q alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (par_valid && (!slot_full_q || final_par)) slot_q <= par_t'(par_data);
  end

  enc_out_reg u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (mes_fire || par_load),
    .in_ready_o  (load_ok),
    .in_beat_i   (load_beat),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_beat_o  (out_beat)
  );

  assign out_data = out_beat.data;
  assign out_par  = out_beat.par;
  assign out_last = out_beat.last;
  assign cw_done  = out_valid && out_ready && out_beat.last;
  assign par_ovf  = ovf_q;

endmodule

// File: tb/tb_enc_cod_serializer.sv
// Self-checking bench for enc_cod_serializer: scoreboard of expected beats
// built from a codeword-order model, plus table scenarios and corner sequences.
module tb_enc_cod_serializer;
  import enc_pkg::*;

  typedef struct packed {
    beat_t data;
    logic  par;
    logic  last;
  } exp_t;

  typedef struct {
    int n_cw;
    int par_idx;
    bit rand_ready;
    int exp_beats;
    bit exp_ovf;
  } scen_t;

  localparam int BUDGET = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst = 1'b1;
  logic  mes_valid = 1'b0;
  logic  mes_ready;
  beat_t mes_data = '0;
  logic  par_valid = 1'b0;
  par_t  par_data = '0;
  logic  out_valid;
  logic  out_ready = 1'b1;
  beat_t out_data;
  logic  out_par;
  logic  out_last;
  logic  cw_done;
  logic  par_ovf;

  enc_cod_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .mes_valid (mes_valid),
    .mes_ready (mes_ready),
    .mes_data  (mes_data),
    .par_valid (par_valid),
    .par_data  (par_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_par   (out_par),
    .out_last  (out_last),
    .cw_done   (cw_done),
    .par_ovf   (par_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Drive-side variables, applied to the DUT at each falling edge.
  bit    drv_rst = 1'b1;
  bit    drv_mes_valid = 1'b0;
  beat_t drv_mes_data = '0;
  bit    drv_par_valid = 1'b0;
  par_t  drv_par_data = '0;
  bit    drv_out_ready = 1'b1;

  // Reference model state.
  exp_t exp_q[$];
  int   mcnt = 0;
  bit   have_par = 1'b0;
  par_t m_par = '0;
  bit   exp_ovf = 1'b0;

  int   cyc = 0;
  int   xfer_cnt = 0;
  int   first_xfer = 0;
  int   last_xfer = 0;
  bit   hold_v = 1'b0;
  exp_t hold_b = '0;
  bit   mes_fired = 1'b0;

  beat_t cur_msg [MES_BEATS];
  par_t  cur_par;
  par_t  cur_par2;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_par(input par_t p);
    for (int k = 0; k < PAR_BEATS; k++) begin
      exp_t e;
      for (int j = 0; j < ENC_SYM; j++) e.data[j] = p[RSC_PAR_LEN - ENC_SYM*(k+1) + j];
      e.par  = 1'b1;
      e.last = (k == PAR_BEATS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_msg(input beat_t d);
    exp_t e;
    e.data = d;
    e.par  = 1'b0;
    e.last = 1'b0;
    exp_q.push_back(e);
    mcnt++;
    if (mcnt == MES_BEATS && have_par) begin
      push_par(m_par);
      have_par = 1'b0;
      mcnt = 0;
    end
  endtask

  task automatic model_par(input par_t p);
    if (have_par) begin
      exp_ovf = 1'b1;
    end else if (mcnt == MES_BEATS) begin
      push_par(p);
      mcnt = 0;
    end else begin
      have_par = 1'b1;
      m_par = p;
    end
  endtask

  task automatic tick();
    exp_t g;
    exp_t e;
    @(negedge clk);
    rst       = drv_rst;
    mes_valid = drv_mes_valid;
    mes_data  = drv_mes_data;
    par_valid = drv_par_valid;
    par_data  = drv_par_data;
    out_ready = drv_out_ready;
    #1;
    g.data = out_data;
    g.par  = out_par;
    g.last = out_last;
    if (out_valid && hold_v) check("stall_hold", 64'(g), 64'(hold_b));
    if (out_valid && out_ready) begin
      xfer_cnt++;
      if (xfer_cnt == 1) first_xfer = cyc;
      last_xfer = cyc;
      if (exp_q.size() == 0) begin
        fail_now($sformatf("extra_beat got %0h required none", g));
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'(g), 64'(e));
        check("cw_done", 64'(cw_done), 64'(e.last));
      end
    end else begin
      check("cw_done_idle", 64'(cw_done), 64'(0));
    end
    hold_v = out_valid && !out_ready;
    hold_b = g;
    mes_fired = mes_valid && mes_ready;
    if (mes_fired) model_msg(mes_data);
    if (par_valid) model_par(par_data);
    cyc++;
  endtask

  task automatic new_cw();
    for (int i = 0; i < MES_BEATS; i++) cur_msg[i] = beat_t'($urandom);
    cur_par  = par_t'({$urandom, $urandom, $urandom, $urandom});
    cur_par2 = par_t'({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic send_msgs(input int n, input int par_idx, input int par2_idx, input bit rnd);
    bit p1 = 1'b0;
    bit p2 = 1'b0;
    for (int idx = 0; idx < n; idx++) begin
      int waited = 0;
      do begin
        drv_mes_valid = 1'b1;
        drv_mes_data  = cur_msg[idx];
        drv_par_valid = 1'b0;
        drv_par_data  = par_t'({$urandom, $urandom, $urandom, $urandom});
        if (idx == par_idx && !p1) begin
          drv_par_valid = 1'b1;
          drv_par_data  = cur_par;
          p1 = 1'b1;
        end else if (idx == par2_idx && !p2) begin
          drv_par_valid = 1'b1;
          drv_par_data  = cur_par2;
          p2 = 1'b1;
        end
        drv_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        waited++;
      end while (!mes_fired && waited < BUDGET);
      if (!mes_fired) begin
        fail_now($sformatf("timeout message beat %0d not accepted", idx));
        break;
      end
    end
    drv_mes_valid = 1'b0;
    drv_par_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int waited = 0;
    drv_mes_valid = 1'b0;
    drv_par_valid = 1'b0;
    while ((exp_q.size() > 0 || out_valid) && waited < BUDGET) begin
      drv_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      waited++;
    end
    if (exp_q.size() > 0) fail_now($sformatf("timeout %0d beats never delivered", exp_q.size()));
    drv_out_ready = 1'b1;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    drv_mes_valid = 1'b0;
    drv_par_valid = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_mes_ready", 64'(mes_ready), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_par", 64'(out_par), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_cw_done", 64'(cw_done), 64'(0));
    check("rst_par_ovf", 64'(par_ovf), 64'(0));
    drv_rst = 1'b0;
    exp_q.delete();
    mcnt = 0;
    have_par = 1'b0;
    exp_ovf = 1'b0;
    hold_v = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t scen [4];
    scen[0] = '{n_cw: 2, par_idx: 1, rand_ready: 1'b1, exp_beats: 24, exp_ovf: 1'b0};
    scen[1] = '{n_cw: 2, par_idx: 7, rand_ready: 1'b1, exp_beats: 24, exp_ovf: 1'b0};
    scen[2] = '{n_cw: 1, par_idx: 4, rand_ready: 1'b0, exp_beats: 12, exp_ovf: 1'b0};
    scen[3] = '{n_cw: 3, par_idx: 5, rand_ready: 1'b1, exp_beats: 36, exp_ovf: 1'b0};

    do_reset();

    // Back-to-back: two codewords, parity during message beat 3, no gaps.
    xfer_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      new_cw();
      send_msgs(MES_BEATS, 3, -1, 1'b0);
    end
    drain(1'b0);
    check("b2b_beats", 64'(xfer_cnt), 64'(24));
    check("b2b_span", 64'(last_xfer - first_xfer + 1), 64'(24));

    // Late parity: arrives 5 cycles after the last message beat.
    new_cw();
    send_msgs(MES_BEATS, -1, -1, 1'b0);
    tick();
    check("late_beat7_valid", 64'(out_valid), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_wait_out_valid", 64'(out_valid), 64'(0));
      check("late_wait_mes_ready", 64'(mes_ready), 64'(0));
    end
    drv_par_valid = 1'b1;
    drv_par_data  = cur_par;
    tick();
    check("late_pulse_out_valid", 64'(out_valid), 64'(0));
    check("late_pulse_mes_ready", 64'(mes_ready), 64'(0));
    drv_par_valid = 1'b0;
    tick();
    check("late_first_par_valid", 64'(out_valid), 64'(1));
    check("late_first_par_flag", 64'(out_par), 64'(1));
    drain(1'b0);

    // Table scenarios with random backpressure.
    foreach (scen[s]) begin
      xfer_cnt = 0;
      for (int c = 0; c < scen[s].n_cw; c++) begin
        new_cw();
        send_msgs(MES_BEATS, scen[s].par_idx, -1, scen[s].rand_ready);
      end
      drain(scen[s].rand_ready);
      check($sformatf("scen%0d_beats", s), 64'(xfer_cnt), 64'(scen[s].exp_beats));
      check($sformatf("scen%0d_ovf", s), 64'(par_ovf), 64'(scen[s].exp_ovf));
    end

    // Overflow: second parity pulse while the first is still held.
    new_cw();
    send_msgs(MES_BEATS, 3, 5, 1'b0);
    drain(1'b0);
    check("ovf_model", 64'(exp_ovf), 64'(1));
    check("ovf_flag", 64'(par_ovf), 64'(1));
    tick();
    check("ovf_sticky", 64'(par_ovf), 64'(1));

    // Boundary: next parity arrives exactly as the final parity beat loads.
    do_reset();
    new_cw();
    send_msgs(MES_BEATS, 3, -1, 1'b0);
    tick();
    tick();
    tick();
    drv_par_valid = 1'b1;
    drv_par_data  = cur_par2;
    tick();
    drv_par_valid = 1'b0;
    new_cw();
    send_msgs(MES_BEATS, -1, -1, 1'b0);
    drain(1'b0);
    check("boundary_no_ovf", 64'(par_ovf), 64'(0));

    // Reset at message beat 5, then a clean codeword from beat 0.
    new_cw();
    send_msgs(5, 3, -1, 1'b0);
    do_reset();
    new_cw();
    send_msgs(MES_BEATS, 3, -1, 1'b0);
    drain(1'b0);
    check("post_reset_ovf", 64'(par_ovf), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
